sdram_avalon_arbiter: RTL

//  Two-requester round-robin arbiter in front of the single Avalon-MM port of the SDRAM controller
//  (active-low read_n/write_n/byteenable_n, waitrequest, readdatavalid).

---
 rtl/sdram_avalon_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sdram_avalon_arbiter.sv
// Two-requester round-robin arbiter in front of the SDRAM controller's Avalon-MM port.
// Commands forward combinationally, and an ID FIFO routes read data back in issue order.
module sdram_avalon_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8,
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = $clog2(MAX_PENDING),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address_i,
  input  logic [DATA_W-1:0] m0_writedata_i,
  input  logic [BE_W-1:0]   m0_byteenable_n_i,
  input  logic              m0_read_n_i,
  input  logic              m0_write_n_i,
  output logic              m0_waitrequest_o,
  output logic [DATA_W-1:0] m0_readdata_o,
  output logic              m0_readdatavalid_o,
  input  logic [ADDR_W-1:0] m1_address_i,
  input  logic [DATA_W-1:0] m1_writedata_i,
  input  logic [BE_W-1:0]   m1_byteenable_n_i,
  input  logic              m1_read_n_i,
  input  logic              m1_write_n_i,
  output logic              m1_waitrequest_o,
  output logic [DATA_W-1:0] m1_readdata_o,
  output logic              m1_readdatavalid_o,
  output logic [ADDR_W-1:0] s_address_o,
  output logic [DATA_W-1:0] s_writedata_o,
  output logic [BE_W-1:0]   s_byteenable_n_o,
  output logic              s_chipselect_o,
  output logic              s_read_n_o,
  output logic              s_write_n_o,
  input  logic              s_waitrequest_i,
  input  logic [DATA_W-1:0] s_readdata_i,
  input  logic              s_readdatavalid_i,
  output logic [CNT_W-1:0]  pending_o,
  output logic              err_orphan_o
);

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             lock_id_q, lock_id_d;
  logic             last_grant_q, last_grant_d;
  logic [MAX_PENDING-1:0] fifo_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_orphan_q;

  logic [1:0] req, rd_only, elig;
  logic       room, fwd, gid, accept, push, pop, head;

  // Avalon handshake: a command transfers on the cycle it is forwarded while s_waitrequest_i is low.
  // The granted requester sees waitrequest low exactly on that cycle.
  assign req     = {~m1_read_n_i | ~m1_write_n_i, ~m0_read_n_i | ~m0_write_n_i};
  assign rd_only = {~m1_read_n_i & m1_write_n_i, ~m0_read_n_i & m0_write_n_i};
  // A pop on this edge frees a slot for a read issued on the same edge.
  assign room    = (count_q != CNT_W'(MAX_PENDING)) | s_readdatavalid_i;
  assign elig    = req & ~(rd_only & {2{~room}});

  always_comb begin
    gid = 1'b0;
    fwd = 1'b0;
    if (state_q == ST_LOCKED) begin
      gid = lock_id_q;
      fwd = elig[lock_id_q];
    end else begin
      fwd = |elig;
      gid = (&elig) ? ~last_grant_q : elig[1];
    end
    if (!reset) fwd = 1'b0;
  end

  assign accept = fwd & ~s_waitrequest_i;
  assign push   = accept & rd_only[gid];
  assign pop    = s_readdatavalid_i & (count_q != '0);
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    s_address_o      = '0;
    s_writedata_o    = '0;
    s_byteenable_n_o = '1;
    s_chipselect_o   = 1'b0;
    s_read_n_o       = 1'b1;
    s_write_n_o      = 1'b1;
    if (fwd) begin
      s_chipselect_o   = 1'b1;
      s_address_o      = gid ? m1_address_i : m0_address_i;
      s_writedata_o    = gid ? m1_writedata_i : m0_writedata_i;
      s_byteenable_n_o = gid ? m1_byteenable_n_i : m0_byteenable_n_i;
      s_write_n_o      = gid ? m1_write_n_i : m0_write_n_i;
      s_read_n_o       = ~rd_only[gid];
    end
  end

  assign m0_waitrequest_o   = ~(accept & ~gid);
  assign m1_waitrequest_o   = ~(accept & gid);
  assign m0_readdata_o      = s_readdata_i;
  assign m1_readdata_o      = s_readdata_i;
  assign m0_readdatavalid_o = pop & ~head;
  assign m1_readdatavalid_o = pop & head;
  assign pending_o          = count_q;
  assign err_orphan_o       = err_orphan_q;

  // A stalled grant is locked so the controller sees a stable command until it accepts it.
  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = ST_OPEN;
      last_grant_d = gid;
    end else if (fwd) begin
      state_d   = ST_LOCKED;
      lock_id_d = gid;
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_OPEN;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= gid;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (s_readdatavalid_i && count_q == '0) err_orphan_q <= 1'b1;
    end
  end

endmodule
